uio_byte_tx: RTL and testbench

- Byte transmitter that drives the bidirectional uio pad bus outward. This is the output-direction counterpart of our existing path, which only reads uio.
- Buffers bytes from core logic in a small FIFO.
- Sends each byte off-chip with a four-phase strobe/acknowledge handshake.
- Releases the bus (output enables low) whenever it is not transmitting.
- Sits between core datapath and the uio_out/uio_oe pad assignments in the top-level wrapper.

---
 rtl/uio_tx_pkg.sv | 20 ++
 rtl/uio_byte_tx_if.sv | 21 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uio_byte_tx.sv | 140 ++++++++++++++
 tb/tb_uio_byte_tx.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uio_tx_pkg.sv
// Shared types and constants for the uio byte transmitter.
package uio_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE,
    ABORT
  } tx_state_t;

  localparam logic [7:0] OE_DRIVE   = 8'hFF;
  localparam logic [7:0] OE_RELEASE = 8'h00;

  // Bits needed for a handshake timer that can hold TIMEOUT.
  function automatic int tmr_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/uio_byte_tx_if.sv
// Core-side byte stream plus the uio pad-side strobe/ack bus.
// master: core logic and the external receiver; slave: the transmitter.
interface uio_byte_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] pin_data;
  logic [7:0] pin_oe;
  logic       pin_stb;
  logic       pin_ack;

  modport master (
    output in_data, in_valid, pin_ack,
    input  in_ready, pin_data, pin_oe, pin_stb
  );

  modport slave (
    input  in_data, in_valid, pin_ack,
    output in_ready, pin_data, pin_oe, pin_stb
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides. No bypass: a byte
// pushed into an empty FIFO becomes visible on the read side one cycle later.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != (AW + 1)'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uio_byte_tx.sv
// Byte transmitter driving the uio pads outward with a four-phase
// strobe/ack handshake; bus is released whenever no byte is in flight.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | bus released; pop next byte once the receiver's ack is low
// SETUP   | data and oe driven, strobe low: one cycle of data setup
// STROBE  | strobe high, waiting for ack to rise (timed)
// RELEASE | strobe low, data still driven, waiting for ack to fall (timed)
// ABORT   | handshake timed out; bus released, byte dropped
module uio_byte_tx
  import uio_tx_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  uio_byte_tx_if.slave     bus,
  output logic             busy,
  output logic             err,
  input  logic             err_clr
);

  localparam int TW = tmr_width(TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  tx_state_t              state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [TW-1:0]          tmr;
  logic [7:0]             pin_data_q;
  logic [7:0]             pin_oe_q;
  logic                   pin_stb_q;
  logic                   err_q;
  logic [7:0]             fifo_data;
  logic                   fifo_valid;
  logic                   fifo_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (bus.in_data),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_data  (fifo_data),
    .out_valid (fifo_valid),
    .out_ready (fifo_pop)
  );

  // Bring the receiver's asynchronous ack into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.pin_ack};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // A new byte only starts once the previous handshake has fully closed.
  assign fifo_pop = (state == IDLE) && fifo_valid && !ack_s;
  assign busy     = fifo_valid || (state != IDLE);

  assign bus.pin_data = pin_data_q;
  assign bus.pin_oe   = pin_oe_q;
  assign bus.pin_stb  = pin_stb_q;
  assign err          = err_q;

  // Handshake FSM with registered pad outputs; the timer is a down-counter
  // loaded on entry to STROBE/RELEASE and aborts when it reaches zero.
  // pin_data doubles as the hold register for the in-flight byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pin_data_q <= '0;
      pin_oe_q   <= OE_RELEASE;
      pin_stb_q  <= 1'b0;
      err_q      <= 1'b0;
      tmr        <= '0;
    end else begin
      // A timeout later in this block overrides the clear.
      if (err_clr) err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            pin_data_q <= fifo_data;
            pin_oe_q   <= OE_DRIVE;
            state      <= SETUP;
          end
        end
        SETUP: begin
          pin_stb_q <= 1'b1;
          tmr       <= TMR_LOAD;
          state     <= STROBE;
        end
        STROBE: begin
          if (ack_s) begin
            pin_stb_q <= 1'b0;
            tmr       <= TMR_LOAD;
            state     <= RELEASE;
          end else if (tmr == '0) begin
            pin_stb_q <= 1'b0;
            pin_oe_q  <= OE_RELEASE;
            err_q     <= 1'b1;
            state     <= ABORT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            pin_oe_q <= OE_RELEASE;
            state    <= IDLE;
          end else if (tmr == '0) begin
            pin_oe_q <= OE_RELEASE;
            err_q    <= 1'b1;
            state    <= ABORT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          pin_stb_q <= 1'b0;
          pin_oe_q  <= OE_RELEASE;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uio_byte_tx.sv
// Bench for uio_byte_tx: table of single-byte transfers plus directed
// sequences for back-pressure, timeouts, err_clr priority, reset and ack-high.
module tb_uio_byte_tx;

  localparam int M_RESP  = 0;
  localparam int M_NEVER = 1;
  localparam int M_HIGH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_clr = 1'b0;
  logic busy;
  logic err;

  uio_byte_tx_if bus();

  uio_byte_tx #(
    .DEPTH       (4),
    .TIMEOUT     (10),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .err     (err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // External receiver model: in responsive mode ack follows stb ~3 cycles late.
  int ack_mode = M_RESP;
  logic [2:0] stb_hist = '0;
  initial bus.pin_ack = 1'b0;
  always @(negedge clk) begin
    if (ack_mode == M_RESP) begin
      stb_hist = {stb_hist[1:0], bus.pin_stb};
      bus.pin_ack = stb_hist[2];
    end else begin
      stb_hist = '0;
      bus.pin_ack = (ack_mode == M_HIGH);
    end
  end

  // Pin monitor: log each strobed byte, check one setup cycle and a bus turnaround.
  logic [7:0] got[$];
  logic       prev_stb = 1'b0;
  logic [7:0] prev_oe = '0;
  logic [7:0] prev_data = '0;
  int         setup_len = 0;
  int         oe_rises = 0;
  always @(negedge clk) begin
    if (bus.pin_stb === 1'b1 && prev_stb === 1'b0) begin
      got.push_back(bus.pin_data);
      check("setup_cycles", setup_len, 1);
      check("setup_data", prev_data, bus.pin_data);
      check("oe_turnaround", oe_rises, 1);
      oe_rises = 0;
    end
    if (bus.pin_oe === 8'hFF && prev_oe === 8'h00) oe_rises++;
    if (bus.pin_oe === 8'hFF && bus.pin_stb === 1'b0) setup_len++;
    else setup_len = 0;
    prev_stb  = bus.pin_stb;
    prev_oe   = bus.pin_oe;
    prev_data = bus.pin_data;
  end

  // Leaves in_valid high so consecutive calls push back-to-back.
  task automatic push(input logic [7:0] b);
    int g = 0;
    bus.in_data = b;
    while (bus.in_ready !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("push_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy !== 1'b0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_stb();
    int g = 0;
    while (bus.pin_stb !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("stb_seen", bus.pin_stb, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         never;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int cnt;
    vecs[0] = '{8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1};
    vecs[4] = '{8'h81, 1'b0, 1'b0};
    vecs[5] = '{8'h7E, 1'b1, 1'b1};

    bus.in_data = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pin_data", bus.pin_data, 8'h00);
    check("rst_pin_oe", bus.pin_oe, 8'h00);
    check("rst_pin_stb", bus.pin_stb, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Single-byte transfers from the table.
    for (int i = 0; i < 6; i++) begin
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      ack_mode = vecs[i].never ? M_NEVER : M_RESP;
      n0 = got.size();
      push(vecs[i].data);
      bus.in_valid = 1'b0;
      wait_idle();
      check("vec_count", got.size(), n0 + 1);
      check("vec_data", got[n0], vecs[i].data);
      check("vec_oe_released", bus.pin_oe, 8'h00);
      check("vec_stb_low", bus.pin_stb, 0);
      check("vec_err", err, vecs[i].exp_err);
    end
    ack_mode = M_RESP;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Five bytes back-to-back into a 4-deep FIFO.
    n0 = got.size();
    for (int i = 1; i <= 5; i++) push(8'(i));
    check("fifo_full_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    wait_idle();
    check("b2b_count", got.size(), n0 + 5);
    for (int i = 0; i < 5; i++) check("b2b_order", got[n0 + i], i + 1);
    check("b2b_err", err, 0);

    // Receiver never acks: 10-cycle strobe, abort, queued byte still goes out.
    ack_mode = M_NEVER;
    n0 = got.size();
    push(8'hAA);
    push(8'hBB);
    bus.in_valid = 1'b0;
    wait_stb();
    cnt = 0;
    while (bus.pin_stb === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_stb_len", cnt, 10);
    check("timeout_err", err, 1);
    check("timeout_oe", bus.pin_oe, 8'h00);
    ack_mode = M_RESP;
    wait_idle();
    check("after_abort_count", got.size(), n0 + 2);
    check("after_abort_byte", got[n0 + 1], 8'hBB);
    check("err_sticky", err, 1);

    // err_clr alone clears; err_clr coincident with a timeout loses.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr_alone", err, 0);
    ack_mode = M_NEVER;
    push(8'h5A);
    bus.in_valid = 1'b0;
    wait_stb();
    repeat (9) @(negedge clk);
    check("pre_timeout_err", err, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_set_priority", err, 1);
    check("err_set_stb", bus.pin_stb, 0);
    ack_mode = M_RESP;
    wait_idle();

    // Reset while strobing with two bytes queued.
    ack_mode = M_NEVER;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    bus.in_valid = 1'b0;
    wait_stb();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_stb", bus.pin_stb, 0);
    check("midrst_oe", bus.pin_oe, 8'h00);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_err", err, 0);
    ack_mode = M_RESP;
    n0 = got.size();
    repeat (40) @(negedge clk);
    check("midrst_no_strobe", got.size(), n0);
    check("midrst_still_idle", busy, 0);

    // Ack held high before the push holds the byte until ack drops.
    ack_mode = M_HIGH;
    repeat (5) @(negedge clk);
    n0 = got.size();
    push(8'hC3);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("ackhigh_stb", bus.pin_stb, 0);
    check("ackhigh_oe", bus.pin_oe, 8'h00);
    check("ackhigh_busy", busy, 1);
    check("ackhigh_no_strobe", got.size(), n0);
    ack_mode = M_RESP;
    wait_idle();
    check("ackhigh_sent_count", got.size(), n0 + 1);
    check("ackhigh_sent_byte", got[n0], 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
